// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and interrupt sequencer state encoding
package cpu_pkg;

    localparam int CPU_PC_W = 32;
    localparam logic [CPU_PC_W-1:0] CPU_VEC_BASE   = 32'h0000_0800;
    localparam logic [CPU_PC_W-1:0] CPU_VEC_STRIDE = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2
    } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-set priority encoder with valid flag
module int_prio_enc #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - nested priority interrupt sequencer with EPC stack
module interrupt_sequencer
    import cpu_pkg::*;
#(
    parameter int                  NUM_SRC    = 3,
    parameter int                  PC_W       = CPU_PC_W,
    parameter logic [PC_W-1:0]     VEC_BASE   = CPU_VEC_BASE,
    parameter logic [PC_W-1:0]     VEC_STRIDE = CPU_VEC_STRIDE,
    parameter logic [NUM_SRC-1:0]  MASK_RST   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               instr_done,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               eret,
    output logic               stall,
    output logic               take_int,
    output logic [PC_W-1:0]    int_vec,
    output logic               ret_int,
    output logic [PC_W-1:0]    epc_out,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service
);

    // Index width must also hold NUM_SRC, the "nothing in service" value of cur.
    localparam int IW = $clog2(NUM_SRC + 1);

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] irq_q, irq_qq, rise, mask, pend_clr, pending_nxt;
    logic [IW-1:0]      sp, win_q, win_idx, cur_idx, cur;
    logic               win_vld, cur_vld, go_enter, go_exit;
    logic [PC_W-1:0]    epc_q;
    logic [PC_W-1:0]    stack [NUM_SRC];

    int_prio_enc #(.N(NUM_SRC), .IW(IW)) u_win_enc (
        .req   (pending & ~mask),
        .idx   (win_idx),
        .valid (win_vld)
    );

    int_prio_enc #(.N(NUM_SRC), .IW(IW)) u_cur_enc (
        .req   (in_service),
        .idx   (cur_idx),
        .valid (cur_vld)
    );

    // Arbitration terms; ERET with an empty stack falls through to normal arbitration.
    always_comb begin
        cur         = cur_vld ? cur_idx : IW'(NUM_SRC);
        rise        = irq_q & ~irq_qq;
        go_exit     = instr_done && eret && (sp != '0);
        go_enter    = instr_done && win_vld && (win_idx < cur);
        pend_clr    = (state == ST_ENTER) ? (NUM_SRC'(1) << win_q) : '0;
        pending_nxt = (pending & ~pend_clr) | rise;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-cycle PC redirect pulses.
    always_comb begin
        state_nxt = state;
        take_int  = 1'b0;
        ret_int   = 1'b0;
        int_vec   = '0;
        epc_out   = '0;
        stall     = (state != ST_RUN);
        case (state)
            ST_RUN: begin
                if (go_exit) begin
                    state_nxt = ST_EXIT;
                end else if (go_enter) begin
                    state_nxt = ST_ENTER;
                end
            end
            ST_ENTER: begin
                take_int  = 1'b1;
                int_vec   = VEC_BASE + PC_W'(win_q) * VEC_STRIDE;
                state_nxt = ST_RUN;
            end
            ST_EXIT: begin
                ret_int   = 1'b1;
                epc_out   = stack[sp - IW'(1)];
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Request latching, mask, EPC stack and in-service bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q      <= '0;
            irq_qq     <= '0;
            mask       <= MASK_RST;
            pending    <= '0;
            in_service <= '0;
            sp         <= '0;
            win_q      <= '0;
            epc_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                stack[i] <= '0;
            end
        end else begin
            irq_q   <= irq_in;
            irq_qq  <= irq_q;
            pending <= pending_nxt;
            if (mask_we) begin
                mask <= mask_din;
            end
            if (state == ST_RUN && !go_exit && go_enter) begin
                win_q <= win_idx;
                epc_q <= pc_next;
            end
            if (state == ST_ENTER) begin
                stack[sp]         <= epc_q;
                sp                <= sp + IW'(1);
                in_service[win_q] <= 1'b1;
            end
            if (state == ST_EXIT) begin
                sp         <= sp - IW'(1);
                in_service <= in_service & (in_service - NUM_SRC'(1));
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq_in;
    logic        mask_we;
    logic [2:0]  mask_din;
    logic        instr_done;
    logic [31:0] pc_next;
    logic        eret;
    logic        stall;
    logic        take_int;
    logic [31:0] int_vec;
    logic        ret_int;
    logic [31:0] epc_out;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .instr_done (instr_done),
        .pc_next    (pc_next),
        .eret       (eret),
        .stall      (stall),
        .take_int   (take_int),
        .int_vec    (int_vec),
        .ret_int    (ret_int),
        .epc_out    (epc_out),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_din = '0;
        instr_done = 1'b0; pc_next = '0; eret = 1'b0;

        // 1. reset state and request edge latency
        step(); step();
        check("rst_stall", stall, 0);
        check("rst_take", take_int, 0);
        check("rst_ret", ret_int, 0);
        check("rst_vec", int_vec, 0);
        check("rst_epc", epc_out, 0);
        check("rst_pend", pending, 0);
        check("rst_insvc", in_service, 0);
        rst_n = 1'b1;
        step();
        irq_in = 3'b010;
        step();
        check("t1_pend_1clk", pending, 3'b000);
        step();
        check("t1_pend_2clk", pending, 3'b010);

        // 2. take source 1
        instr_done = 1'b1; pc_next = 32'h0040;
        step();
        instr_done = 1'b0;
        check("t2_take", take_int, 1);
        check("t2_vec", int_vec, 32'h0810);
        check("t2_stall", stall, 1);
        step();
        check("t2_insvc", in_service, 3'b010);
        check("t2_pend", pending, 3'b000);
        check("t2_stall_off", stall, 0);

        // 3. lower priority source 2 cannot preempt, source 0 can
        irq_in = 3'b110;
        step(); step();
        check("t3_pend2", pending, 3'b100);
        instr_done = 1'b1; pc_next = 32'h0050;
        step();
        instr_done = 1'b0;
        check("t3_no_take2", take_int, 0);
        check("t3_no_stall2", stall, 0);
        irq_in = 3'b111;
        step(); step();
        check("t3_pend02", pending, 3'b101);
        instr_done = 1'b1; pc_next = 32'h0814;
        step();
        instr_done = 1'b0;
        check("t3_take0", take_int, 1);
        check("t3_vec0", int_vec, 32'h0800);
        step();
        check("t3_insvc", in_service, 3'b011);
        check("t3_pend_left", pending, 3'b100);

        // 4. nested returns, then the deferred source 2
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t4_ret1", ret_int, 1);
        check("t4_epc1", epc_out, 32'h0814);
        check("t4_stall1", stall, 1);
        step();
        check("t4_insvc1", in_service, 3'b010);
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t4_ret2", ret_int, 1);
        check("t4_epc2", epc_out, 32'h0040);
        step();
        check("t4_insvc2", in_service, 3'b000);
        instr_done = 1'b1; pc_next = 32'h0100;
        step();
        instr_done = 1'b0;
        check("t4_take2", take_int, 1);
        check("t4_vec2", int_vec, 32'h0820);
        step();
        check("t4_insvc3", in_service, 3'b100);
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t4_ret3", ret_int, 1);
        check("t4_epc3", epc_out, 32'h0100);
        step();

        // 5. masked source stays pending and is not taken
        mask_we = 1'b1; mask_din = 3'b001;
        step();
        mask_we = 1'b0;
        irq_in = 3'b000;
        step();
        irq_in = 3'b001;
        step(); step();
        check("t5_pend", pending, 3'b001);
        instr_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t5_masked_%0d", i), take_int, 0);
        end
        instr_done = 1'b0;
        mask_we = 1'b1; mask_din = 3'b000;
        step();
        mask_we = 1'b0;
        instr_done = 1'b1; pc_next = 32'h0200;
        step();
        instr_done = 1'b0;
        check("t5_take", take_int, 1);
        check("t5_vec", int_vec, 32'h0800);
        step();
        check("t5_insvc", in_service, 3'b001);
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t5_ret", ret_int, 1);
        step();

        // 6. ERET on empty stack, reset during ENTER
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t6_no_ret", ret_int, 0);
        check("t6_no_stall", stall, 0);
        irq_in = 3'b000;
        step(); step();
        irq_in = 3'b001;
        step(); step();
        check("t6_pend", pending, 3'b001);
        instr_done = 1'b1; pc_next = 32'h0300;
        step();
        instr_done = 1'b0;
        check("t6_take", take_int, 1);
        rst_n = 1'b0; irq_in = 3'b000;
        step();
        check("t6_rst_take", take_int, 0);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_pend", pending, 0);
        check("t6_rst_insvc", in_service, 0);
        rst_n = 1'b1;
        step();
        instr_done = 1'b1; eret = 1'b1;
        step();
        instr_done = 1'b0; eret = 1'b0;
        check("t6_sp_zero", ret_int, 0);
        check("t6_sp_zero_stall", stall, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
